// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter and fetch sequencing with saved-address registers
//
// Purpose: produces the instruction ROM address each cycle. It keeps three
// saved-address registers (PCreg1..3) used as loop/branch targets, resolves
// je/jne against the ALU equal flag, and brackets each program run with an
// IDLE -> RUN -> DONE state machine.
//
// Ports:
//   Clk          in   rising-edge clock
//   Reset        in   asynchronous active-low reset
//   Start        in   begin or restart a program run
//   Ack          in   decoder done with program; ends the run
//   Stall        in   freeze PC, saves and jumps this cycle
//   JumpEqual    in   current instruction is je
//   JumpNotEqual in   current instruction is jne
//   PCRegSelect  in   00 none, 01/10/11 select PCreg1/2/3
//   SaveEn       in   capture ProgCtr+1 into the selected PCreg
//   EqualFlag    in   ALU equal/zero flag for the current instruction
//   ProgCtr      out  instruction ROM address
//   Running      out  state is RUN
//   Done         out  state is DONE
//   JumpTaken    out  a taken jump updated ProgCtr at the previous edge
module fetch_unit #(
  parameter int PC_WIDTH   = 10,
  parameter int START_ADDR = 0
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Ack,
  input  logic                Stall,
  input  logic                JumpEqual,
  input  logic                JumpNotEqual,
  input  logic [1:0]          PCRegSelect,
  input  logic                SaveEn,
  input  logic                EqualFlag,
  output logic [PC_WIDTH-1:0] ProgCtr,
  output logic                Running,
  output logic                Done,
  output logic                JumpTaken
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] START_PC = PC_WIDTH'(START_ADDR);

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pcreg1_q, pcreg1_d;
  logic [PC_WIDTH-1:0] pcreg2_q, pcreg2_d;
  logic [PC_WIDTH-1:0] pcreg3_q, pcreg3_d;
  logic                running_q, running_d;
  logic                done_q, done_d;
  logic                jump_taken_q, jump_taken_d;

  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] jump_target;
  logic                sel_nz;
  logic                taken;

  // Wraps modulo 2^PC_WIDTH by construction of the vector width.
  assign pc_inc = pc_q + PC_WIDTH'(1);
  assign sel_nz = (PCRegSelect != 2'b00);
  assign taken  = sel_nz && ((JumpEqual && EqualFlag) || (JumpNotEqual && !EqualFlag));

  // Jump target always comes from the register's current value, so a save
  // to the same register in the same cycle does not affect this jump.
  always_comb begin
    jump_target = pc_inc;
    case (PCRegSelect)
      2'b01:   jump_target = pcreg1_q;
      2'b10:   jump_target = pcreg2_q;
      2'b11:   jump_target = pcreg3_q;
      default: jump_target = pc_inc;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pcreg1_d     = pcreg1_q;
    pcreg2_d     = pcreg2_q;
    pcreg3_d     = pcreg3_q;
    jump_taken_d = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (Start) begin
          pc_d     = START_PC;
          pcreg1_d = '0;
          pcreg2_d = '0;
          pcreg3_d = '0;
        end else if (Ack) begin
          state_d = ST_DONE;
        end else if (!Stall) begin
          pc_d         = taken ? jump_target : pc_inc;
          jump_taken_d = taken;
          if (SaveEn) begin
            case (PCRegSelect)
              2'b01:   pcreg1_d = pc_inc;
              2'b10:   pcreg2_d = pc_inc;
              2'b11:   pcreg3_d = pc_inc;
              default: ;
            endcase
          end
        end
      end
      default: begin
        // IDLE and DONE only react to Start.
        if (Start) begin
          state_d  = ST_RUN;
          pc_d     = START_PC;
          pcreg1_d = '0;
          pcreg2_d = '0;
          pcreg3_d = '0;
        end
      end
    endcase

    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= START_PC;
      pcreg1_q     <= '0;
      pcreg2_q     <= '0;
      pcreg3_q     <= '0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      jump_taken_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pcreg1_q     <= pcreg1_d;
      pcreg2_q     <= pcreg2_d;
      pcreg3_q     <= pcreg3_d;
      running_q    <= running_d;
      done_q       <= done_d;
      jump_taken_q <= jump_taken_d;
    end
  end

  assign ProgCtr   = pc_q;
  assign Running   = running_q;
  assign Done      = done_q;
  assign JumpTaken = jump_taken_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit
module tb_fetch_unit;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic       Ack = 1'b0;
  logic       Stall = 1'b0;
  logic       JumpEqual = 1'b0;
  logic       JumpNotEqual = 1'b0;
  logic [1:0] PCRegSelect = 2'b00;
  logic       SaveEn = 1'b0;
  logic       EqualFlag = 1'b0;

  logic [9:0] pc;
  logic       running, done, jt;
  logic [3:0] pc4;
  logic       running4, done4, jt4;

  int total = 0;
  int bad = 0;

  always #5 Clk = ~Clk;

  fetch_unit #(.PC_WIDTH(10), .START_ADDR(0)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Stall(Stall),
    .JumpEqual(JumpEqual), .JumpNotEqual(JumpNotEqual), .PCRegSelect(PCRegSelect),
    .SaveEn(SaveEn), .EqualFlag(EqualFlag),
    .ProgCtr(pc), .Running(running), .Done(done), .JumpTaken(jt)
  );

  fetch_unit #(.PC_WIDTH(4), .START_ADDR(14)) dut4 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Stall(Stall),
    .JumpEqual(JumpEqual), .JumpNotEqual(JumpNotEqual), .PCRegSelect(PCRegSelect),
    .SaveEn(SaveEn), .EqualFlag(EqualFlag),
    .ProgCtr(pc4), .Running(running4), .Done(done4), .JumpTaken(jt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    Start = 1'b0; Ack = 1'b0; Stall = 1'b0; JumpEqual = 1'b0; JumpNotEqual = 1'b0;
    PCRegSelect = 2'b00; SaveEn = 1'b0; EqualFlag = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_pc", 32'(pc), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_jt", 32'(jt), 0);
    chk("rst_pc4", 32'(pc4), 14);
    #1 Reset = 1'b1;
    step();
    chk("idle_pc", 32'(pc), 0);
    chk("idle_running", 32'(running), 0);

    // Start and free run; the 4-bit instance wraps 14,15,0,1
    Start = 1'b1;
    step();
    Start = 1'b0;
    chk("start_pc", 32'(pc), 0);
    chk("start_running", 32'(running), 1);
    chk("start_pc4", 32'(pc4), 14);
    step(); chk("run_pc1", 32'(pc), 1); chk("wrap_15", 32'(pc4), 15); chk("run_jt", 32'(jt), 0);
    step(); chk("run_pc2", 32'(pc), 2); chk("wrap_0", 32'(pc4), 0);
    step(); chk("run_pc3", 32'(pc), 3); chk("wrap_1", 32'(pc4), 1);

    // Save at PC 3 into PCreg1 -> 4
    SaveEn = 1'b1; PCRegSelect = 2'b01;
    step(); clr();
    chk("save_pc4", 32'(pc), 4); chk("save_jt", 32'(jt), 0);
    step(); chk("run_pc5", 32'(pc), 5); chk("run_running", 32'(running), 1);
    step(); chk("run_pc6", 32'(pc), 6);
    step(); chk("run_pc7", 32'(pc), 7); chk("run_jt7", 32'(jt), 0);

    // jne at PC 7, flag 0 -> PCreg1
    JumpNotEqual = 1'b1; PCRegSelect = 2'b01; EqualFlag = 1'b0;
    step(); clr();
    chk("jne_taken_pc", 32'(pc), 4); chk("jne_taken_jt", 32'(jt), 1);
    step(); chk("after_jump_pc", 32'(pc), 5); chk("jt_one_cycle", 32'(jt), 0);
    step(); step(); chk("back_to_7", 32'(pc), 7);

    // jne at PC 7, flag 1 -> fall through
    JumpNotEqual = 1'b1; PCRegSelect = 2'b01; EqualFlag = 1'b1;
    step(); clr();
    chk("jne_not_taken_pc", 32'(pc), 8); chk("jne_not_taken_jt", 32'(jt), 0);
    step(); chk("reach_9", 32'(pc), 9);

    // Stall 3 cycles at PC 9 with a pending je
    JumpEqual = 1'b1; EqualFlag = 1'b1; PCRegSelect = 2'b01; Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", 32'(pc), 9);
      chk("stall_jt", 32'(jt), 0);
    end
    Stall = 1'b0;
    step(); clr();
    chk("unstall_pc", 32'(pc), 4); chk("unstall_jt", 32'(jt), 1);

    // Run to 11, save into PCreg2 -> 12
    for (int i = 5; i <= 11; i++) begin
      step();
      chk("run_to_11", 32'(pc), 32'(i));
    end
    SaveEn = 1'b1; PCRegSelect = 2'b10;
    step(); clr();
    chk("save2_pc", 32'(pc), 12);
    for (int i = 13; i <= 20; i++) step();
    chk("reach_20", 32'(pc), 20);

    // je + save on PCreg2 in the same cycle: jump uses old 12, reg becomes 21
    JumpEqual = 1'b1; EqualFlag = 1'b1; PCRegSelect = 2'b10; SaveEn = 1'b1;
    step(); clr();
    chk("save_jump_pc", 32'(pc), 12); chk("save_jump_jt", 32'(jt), 1);
    JumpNotEqual = 1'b1; PCRegSelect = 2'b10; EqualFlag = 1'b0;
    step(); clr();
    chk("pcreg2_new", 32'(pc), 21); chk("pcreg2_jt", 32'(jt), 1);

    // je with select 00 falls through
    JumpEqual = 1'b1; EqualFlag = 1'b1; PCRegSelect = 2'b00;
    step(); clr();
    chk("je_sel0_pc", 32'(pc), 22); chk("je_sel0_jt", 32'(jt), 0);

    // je and jne together: taken regardless of flag
    JumpEqual = 1'b1; JumpNotEqual = 1'b1; PCRegSelect = 2'b01; EqualFlag = 1'b0;
    step(); clr();
    chk("both_pc", 32'(pc), 4); chk("both_jt", 32'(jt), 1);

    // Run to 15, Ack together with a taken jump
    for (int i = 5; i <= 15; i++) step();
    chk("reach_15", 32'(pc), 15);
    Ack = 1'b1; JumpEqual = 1'b1; EqualFlag = 1'b1; PCRegSelect = 2'b01; SaveEn = 1'b1;
    step();
    chk("ack_pc", 32'(pc), 15); chk("ack_done", 32'(done), 1);
    chk("ack_running", 32'(running), 0); chk("ack_jt", 32'(jt), 0);
    Stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("done_hold_pc", 32'(pc), 15);
      chk("done_hold_done", 32'(done), 1);
      chk("done_hold_jt", 32'(jt), 0);
    end
    clr();

    // Restart from DONE; PCregs read back as 0 via jumps
    Start = 1'b1;
    step(); clr();
    chk("restart_pc", 32'(pc), 0); chk("restart_running", 32'(running), 1);
    chk("restart_done", 32'(done), 0);
    for (int s = 1; s <= 3; s++) begin
      JumpNotEqual = 1'b1; EqualFlag = 1'b0; PCRegSelect = 2'(s);
      step(); clr();
      chk("pcreg_cleared", 32'(pc), 0);
      chk("pcreg_cleared_jt", 32'(jt), 1);
    end

    // Held Start keeps ProgCtr at START_ADDR; restart clears PCregs from RUN
    step(); step(); chk("pre_hold_pc", 32'(pc), 2);
    Start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("held_start_pc", 32'(pc), 0);
      chk("held_start_running", 32'(running), 1);
    end
    Start = 1'b0;
    step(); chk("post_hold_1", 32'(pc), 1);
    step(); chk("post_hold_2", 32'(pc), 2);

    // Asynchronous reset mid-cycle
    #3 Reset = 1'b0;
    #1;
    chk("async_rst_pc", 32'(pc), 0);
    chk("async_rst_running", 32'(running), 0);
    chk("async_rst_jt", 32'(jt), 0);
    chk("async_rst_pc4", 32'(pc4), 14);
    #2 Reset = 1'b1;
    step(); step();
    chk("post_rst_idle_pc", 32'(pc), 0);
    chk("post_rst_idle_running", 32'(running), 0);
    chk("post_rst_idle_done", 32'(done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
